// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
//   Round-robin arbiter that shares one 16:1 bit-select mux among 16 requesters.
//   It registers a select index and a one-hot grant.
//   A grant lasts until one of the following happens:
//     - the owner pulses done,
//     - the owner drops its request,
//     - the hold timer expires.
//   Every release is followed by one dead cycle.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   req[15:0]     request vector, level-held by each requester
//   done          release pulse from the current owner (ignored when idle)
//   grant_valid   mux is owned; grant_sel is meaningful
//   grant_sel     owner index; drives the mux select; keeps its value after release
//   grant_onehot  one-hot owner; zero when grant_valid=0
//   timeout       one-cycle pulse when a grant ends purely by hold expiry
module mux16_rr_arbiter #(
    parameter int N_REQ    = 16,
    parameter int SEL_W    = 4,
    parameter int HOLD_W   = 8,
    parameter int MAX_HOLD = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_sel,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    // The counter holds (cycles granted - 1).
    // So the last allowed cycle is when the counter reaches MAX_HOLD-1.
    localparam int HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_LAST_I[HOLD_W-1:0];
    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  ptr, ptr_nxt;
    logic [HOLD_W-1:0] cnt, cnt_nxt;
    logic              valid_nxt, timeout_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [N_REQ-1:0]  onehot_nxt;

    // Rotating priority scan.
    // The scan walks offsets from high to low, so the smallest offset from ptr wins.
    // The index arithmetic is SEL_W bits wide, which makes the wrap from 15 to 0 free.
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr;
        scan_idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ptr + SEL_W'(k);
            if (req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    logic owner_req, expire;
    assign owner_req = req[grant_sel];
    assign expire    = TIMEOUT_EN && (cnt == HOLD_LAST);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        valid_nxt   = grant_valid;
        sel_nxt     = grant_sel;
        onehot_nxt  = grant_onehot;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt  = GRANT;
                    valid_nxt  = 1'b1;
                    sel_nxt    = pick_idx;
                    onehot_nxt = N_REQ'(1) << pick_idx;
                    ptr_nxt    = pick_idx + 1'b1;
                    cnt_nxt    = '0;
                end
            end
            GRANT: begin
                if (done || !owner_req || expire) begin
                    state_nxt   = IDLE;
                    valid_nxt   = 1'b0;
                    onehot_nxt  = '0;
                    // Flag only releases caused by expiry alone.
                    timeout_nxt = expire && !done && owner_req;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            grant_valid  <= 1'b0;
            grant_sel    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            cnt          <= cnt_nxt;
            grant_valid  <= valid_nxt;
            grant_sel    <= sel_nxt;
            grant_onehot <= onehot_nxt;
            timeout      <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
module tb_mux16_rr_arbiter;

    localparam int MAXH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic        grant_valid;
    logic [3:0]  grant_sel;
    logic [15:0] grant_onehot;
    logic        timeout;

    mux16_rr_arbiter #(.N_REQ(16), .SEL_W(4), .HOLD_W(8), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .grant_valid(grant_valid), .grant_sel(grant_sel),
        .grant_onehot(grant_onehot), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model.
    // The owner is tracked as an integer.
    // The hold time is the number of cycles the grant has been visible.
    bit m_valid;
    int m_sel;
    int m_ptr;
    int m_held;
    bit m_to;

    task automatic model_reset();
        m_valid = 0; m_sel = 0; m_ptr = 0; m_held = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic d);
        m_to = 0;
        if (!m_valid) begin
            for (int k = 0; k < 16; k++) begin
                int idx;
                idx = (m_ptr + k) % 16;
                if (r[idx]) begin
                    m_valid = 1; m_sel = idx; m_ptr = (idx + 1) % 16; m_held = 1;
                    break;
                end
            end
        end else begin
            bit exp_hit;
            exp_hit = (MAXH != 0) && (m_held == MAXH);
            if (d || !r[m_sel] || exp_hit) begin
                m_valid = 0;
                m_to = exp_hit && !d && r[m_sel];
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  32'(grant_valid),  32'(m_valid));
        chk({tag, ".sel"},    32'(grant_sel),    32'(m_sel));
        chk({tag, ".onehot"}, 32'(grant_onehot), m_valid ? (32'd1 << m_sel) : 32'd0);
        chk({tag, ".timeout"},32'(timeout),      32'(m_to));
    endtask

    // Drive inputs, advance one edge in both the model and the DUT, then compare.
    task automatic step(input logic [15:0] r, input logic d, input string tag);
        req = r; done = d;
        model_edge(r, d);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    // Reset is asserted between edges, so the outputs must clear with no clock edge.
    task automatic do_reset(input string tag);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
        req = '0; done = 1'b0;
    endtask

    initial begin
        int hold_len;
        logic [15:0] rr;
        rst = 1'b1; req = '0; done = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk); rst = 1'b0;

        // A single request is granted on the next edge.
        step(16'h0001, 1'b0, "first_grant");
        chk("first_sel", 32'(grant_sel), 32'd0);
        chk("first_oh",  32'(grant_onehot), 32'h0001);

        // Fairness: each grant is released by done, which leaves one dead cycle between grants.
        do_reset("reset2");
        for (int g = 0; g < 17; g++) begin
            step(16'hFFFF, 1'b0, "rr_grant");
            chk("rr_seq", 32'(grant_sel), 32'(g % 16));
            step(16'hFFFF, 1'b1, "rr_release");
        end

        // Wrap-around: own index 4, then requests 0 and 4 must pick 0, and after that 4.
        do_reset("reset3");
        step(16'h0010, 1'b0, "wrap_g4");
        step(16'h0000, 1'b0, "wrap_rel");
        step(16'h0011, 1'b0, "wrap_g0");
        chk("wrap_sel0", 32'(grant_sel), 32'd0);
        step(16'h0011, 1'b1, "wrap_rel2");
        step(16'h0011, 1'b0, "wrap_g4b");
        chk("wrap_sel4", 32'(grant_sel), 32'd4);

        // Timeout: a held request with no done stays granted for MAXH cycles.
        do_reset("reset4");
        hold_len = 0;
        step(16'h0008, 1'b0, "to_grant");
        for (int c = 0; c < 40 && grant_valid; c++) begin
            hold_len++;
            step(16'h0008, 1'b0, "to_hold");
        end
        chk("to_len", 32'(hold_len), 32'(MAXH));
        chk("to_pulse", 32'(timeout), 32'd1);
        step(16'h0008, 1'b0, "to_after");
        chk("to_once", 32'(timeout), 32'd0);

        // A done that coincides with expiry is a normal release.
        do_reset("reset5");
        step(16'h0008, 1'b0, "dn_grant");
        for (int c = 0; c < MAXH - 1; c++) step(16'h0008, 1'b0, "dn_hold");
        step(16'h0008, 1'b1, "dn_rel");
        chk("dn_valid", 32'(grant_valid), 32'd0);
        chk("dn_nopulse", 32'(timeout), 32'd0);

        // Reset mid-grant clears everything, and the priority pointer restarts at 0.
        do_reset("reset6");
        step(16'h0040, 1'b0, "mr_grant");
        do_reset("mid_reset");
        step(16'hFFFF, 1'b0, "mr_after");
        chk("mr_ptr0", 32'(grant_sel), 32'd0);

        // Random traffic: requests persist with occasional bit flips.
        rr = 16'h0000;
        for (int n = 0; n < 3000; n++) begin
            if (n % 500 == 499) do_reset("rnd_reset");
            for (int b = 0; b < 16; b++)
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            step(rr, ($urandom_range(0, 5) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
